datapath_p: RTL
===============

# datapath_p

Parametrised successor to the lab datapath: register file, A/B/C pipeline registers, shifter, extended ALU with NZVC status, program counter and instruction register, all generic in data width, register count and PC width. It sits between the FSM controller, which drives every load/select strobe, and instruction/data memory, which supplies `mdata` and consumes `PC` and `datapath_out`. New relative to the fixed 16-bit version: 3-bit ALU op set, carry/overflow flags, add-with-carry, selectable PC source, and a fully resettable register file.

## Interface
- WIDTH, 16, datapath and register width (≥4)
- NREGS, 8, register count; power of two, ≥2; RW = log2(NREGS)
- PCW, 8, program-counter width (≤WIDTH)
- clk  in  1  clock; every register updates on the rising edge
- reset  in  1  synchronous, active-high; one clock is synchronous, reset is synchronous and active-high
- write  in  1  register-file write enable
- writenum, readnum  in  RW  write/read register index
- vsel  in  2  write-data source: 00 C, 01 sximm8, 10 zero-extended PC, 11 mdata
- mdata  in  WIDTH  memory read data; also IR load source
- sximm5, sximm8  in  WIDTH  sign-extended immediates
- loada, loadb, loadc, loads, loadIR, loadPC  in  1  register enables
- asel  in  1  1: ALU A input = 0, else A register
- bsel  in  1  1: ALU B input = sximm5, else shifted B
- shift  in  2  00 none, 01 LSL1, 10 LSR1, 11 ASR1 (applied to B)
- ALUop  in  3  operation, see Operation
- pcsel  in  2  00 PC+1, 01 C[PCW-1:0], 10 PC+1+sximm8[PCW-1:0], 11 hold
- datapath_out  out  WIDTH  C register
- status  out  4  {N,Z,V,C} (bit 3 = N, bit 0 = C)
- PC  out  PCW  program counter
- IRout  out  WIDTH  instruction register

## Operation
- Register file: single read port (combinational on readnum), single write port; write on edge when write=1.
- ALUop: 000 ADD, 001 SUB (A−B), 010 AND, 011 MVN (~B), 100 OR, 101 XOR, 110 ADC (A+B+status.C), 111 MOV (B).
- Arithmetic in WIDTH+1 bits. C = carry-out for ADD/ADC; for SUB C = 1 when no borrow (A ≥ B unsigned). V = signed overflow for ADD/SUB/ADC. Logical ops and MOV: V=0, C=0.
- N = result MSB; Z = result all-zero. status updates only when loads=1.
- C register loads ALU result when loadc=1; status and C load independently.
- PC arithmetic modulo 2^PCW; wraps all-ones → 0 without flag.
- IR loads mdata when loadIR=1.
- vsel=10: PC zero-extended to WIDTH.

## Timing
- Reset (sampled on edge): all NREGS registers, A, B, C, status, PC, IR ← 0. Reset overrides every enable; asserting mid-sequence aborts it with no partial write.
- Outputs are registered; no combinational path from inputs to outputs.
- Register read → A/B: 1 edge. A/B → C/status: 1 edge. C → register file (vsel=00): 1 edge. Single read port, so a two-operand op takes 4 edges from first readnum to writeback.
- Same-edge write and read of one index: A/B capture the old value; no forwarding.
- ADC uses status.C as held before the edge, including when loads=1 on that edge.
- pcsel=01 uses C before the edge; loadc and loadPC on one edge give PC the old C.
- loadPC=0 or pcsel=11: PC holds.

## Test plan
- Reset: preload R5=0x00AA, PC=0x12; pulse reset one edge → PC=0, IRout=0, datapath_out=0, status=0000; read R5 via MOV → C=0x0000.
- ADD with shift: R0=7, R1=2 via vsel=01; B←R0, A←R1, shift=01, ADD, loadc/loads → datapath_out=0x0010, status=0000.
- SUB overflow: A=0x8000, B=0x0001, SUB → 0x7FFF, status=0011 (V=1, C=1); then A=0x0001, B=0x0002 SUB → 0xFFFF, status=1000.
- Carry chain: A=0xFFFF, B=0x0001 ADD → 0x0000, status=0101; then A=B=0 ADC → 0x0001, status=0000; repeat with loads=0 → status unchanged.
- PC: PC=0xFF, pcsel=00 → 0x00; C=0x1234, pcsel=01 → 0x34; PC=0x10, sximm8=0xFFFE, pcsel=10 → 0x0F; pcsel=11 → holds.
- Hazard: R3=9; same edge write R3←5 and loada with readnum=3 → A=9; next read → 5. IR: mdata=0xD107, loadIR → IRout=0xD107.

Source files
------------

// File: rtl/datapath_p_if.sv
// datapath_p_if: controller/memory-facing strobes and results of the parametrised datapath.
interface datapath_p_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 8
);
  localparam int RW = $clog2(NREGS);
  logic             write;
  logic [RW-1:0]    writenum;
  logic [RW-1:0]    readnum;
  logic [1:0]       vsel;
  logic [WIDTH-1:0] mdata;
  logic [WIDTH-1:0] sximm5;
  logic [WIDTH-1:0] sximm8;
  logic             loada;
  logic             loadb;
  logic             loadc;
  logic             loads;
  logic             loadIR;
  logic             loadPC;
  logic             asel;
  logic             bsel;
  logic [1:0]       shift;
  logic [2:0]       ALUop;
  logic [1:0]       pcsel;
  logic [WIDTH-1:0] datapath_out;
  logic [3:0]       status;
  logic [PCW-1:0]   PC;
  logic [WIDTH-1:0] IRout;
  modport master (
    output write, writenum, readnum, vsel, mdata, sximm5, sximm8,
           loada, loadb, loadc, loads, loadIR, loadPC, asel, bsel, shift, ALUop, pcsel,
    input  datapath_out, status, PC, IRout
  );
  modport slave (
    input  write, writenum, readnum, vsel, mdata, sximm5, sximm8,
           loada, loadb, loadc, loads, loadIR, loadPC, asel, bsel, shift, ALUop, pcsel,
    output datapath_out, status, PC, IRout
  );
endinterface

// File: rtl/datapath_p.sv
// datapath_p: register file, A/B/C pipeline, shifter, NZVC ALU, PC and IR, all generic in width.
module datapath_p #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 8
) (
  input logic          clk,
  input logic          reset,
  datapath_p_if.slave  bus
);
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, ir_q, ir_d;
  logic [3:0]       status_q, status_d;
  logic [PCW-1:0]   pc_q, pc_d, pc_inc, pc_rel;
  logic [WIDTH-1:0] wdata, rdata, b_sh, ain, bin, op2, res;
  logic [WIDTH:0]   sum;
  logic             cin, arith, v_flag, c_flag;
  assign rdata = regs_q[bus.readnum];
  assign wdata = bus.vsel == 2'b00 ? c_q :
                 bus.vsel == 2'b01 ? bus.sximm8 :
                 bus.vsel == 2'b10 ? WIDTH'(pc_q) : bus.mdata;
  assign b_sh = bus.shift == 2'b00 ? b_q :
                bus.shift == 2'b01 ? {b_q[WIDTH-2:0], 1'b0} :
                bus.shift == 2'b10 ? {1'b0, b_q[WIDTH-1:1]} : {b_q[WIDTH-1], b_q[WIDTH-1:1]};
  assign ain = bus.asel ? '0 : a_q;
  assign bin = bus.bsel ? bus.sximm5 : b_sh;
  // SUB is A + ~B + 1, so carry-out doubles as the "no borrow" flag
  assign op2   = bus.ALUop == 3'b001 ? ~bin : bin;
  assign cin   = bus.ALUop == 3'b001 ? 1'b1 : bus.ALUop == 3'b110 ? status_q[0] : 1'b0;
  assign sum   = {1'b0, ain} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
  assign arith = bus.ALUop == 3'b000 || bus.ALUop == 3'b001 || bus.ALUop == 3'b110;
  always_comb begin
    case (bus.ALUop)
      3'b010:  res = ain & bin;
      3'b011:  res = ~bin;
      3'b100:  res = ain | bin;
      3'b101:  res = ain ^ bin;
      3'b111:  res = bin;
      default: res = sum[WIDTH-1:0];
    endcase
  end
  assign v_flag = arith && (ain[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]);
  assign c_flag = arith && sum[WIDTH];
  assign pc_inc = pc_q + PCW'(1);
  assign pc_rel = pc_inc + bus.sximm8[PCW-1:0];
  always_comb begin
    regs_d = regs_q;
    if (bus.write) regs_d[bus.writenum] = wdata;
    a_d      = bus.loada ? rdata : a_q;
    b_d      = bus.loadb ? rdata : b_q;
    c_d      = bus.loadc ? res : c_q;
    status_d = bus.loads ? {res[WIDTH-1], res == '0, v_flag, c_flag} : status_q;
    ir_d     = bus.loadIR ? bus.mdata : ir_q;
    pc_d     = !bus.loadPC ? pc_q :
               bus.pcsel == 2'b00 ? pc_inc :
               bus.pcsel == 2'b01 ? c_q[PCW-1:0] :
               bus.pcsel == 2'b10 ? pc_rel : pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      ir_q     <= '0;
      pc_q     <= '0;
    end else begin
      regs_q   <= regs_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
    end
  end
  assign bus.datapath_out = c_q;
  assign bus.status       = status_q;
  assign bus.PC           = pc_q;
  assign bus.IRout        = ir_q;
endmodule
